// File: rtl/gpio_slave_irq_if.sv
// gpio_slave_irq_if
//   Peripheral-bus bundle for the GPIO slave: word-indexed write and read
//   strobes, registered read data and registered access error.
//
//   Signals (named from the slave's point of view):
//     i_WEnable  write strobe, one cycle per access
//     i_WAddr    write word index
//     i_WData    write data
//     i_REnable  read strobe, one cycle per access
//     i_RAddr    read word index
//     o_RData    registered read data
//     o_Err      registered access error
//
//   Modports: master drives strobes/address/data, slave returns data/error.
interface gpio_slave_irq_if;
    logic        i_WEnable;
    logic [31:0] i_WAddr;
    logic [31:0] i_WData;
    logic        i_REnable;
    logic [31:0] i_RAddr;
    logic [31:0] o_RData;
    logic        o_Err;

    modport master (
        output i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
        input  o_RData, o_Err
    );

    modport slave (
        input  i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
        output o_RData, o_Err
    );
endinterface

// File: rtl/gpio_slave_irq.sv
// gpio_slave_irq
//   Parametrised GPIO bus slave with per-pin direction, atomic set/clear/
//   toggle of the output register, a synchronised input path, per-pin
//   rising/falling edge capture into a write-1-to-clear STATUS register
//   and one registered level interrupt.
//
//   Register map (word index): 0 DIR, 1 OUT, 2 IN (RO), 3 OUT_SET (WO),
//   4 OUT_CLR (WO), 5 OUT_TGL (WO), 6 IRQ_EN, 7 EDGE_RISE, 8 EDGE_FALL,
//   9 STATUS (W1C). Index > 9, or a write to IN, flags o_Err and changes
//   nothing. Write-only registers read as 0.
//
//   Ports:
//     i_Clk, i_Rst_n  clock, asynchronous active-low reset
//     bus             gpio_slave_irq_if.slave peripheral bus
//     i_Pin_In        asynchronous pin inputs
//     o_Pin_Out       OUT register
//     o_Pin_Oe        DIR register, 1 = drive
//     o_Irq           registered |(STATUS & IRQ_EN)
//
//   Optional feature: define GPIO_DEBOUNCE_EN to insert a per-pin
//   debouncer (DEBOUNCE_CYCLES stable cycles) between the synchroniser and
//   the IN register / edge detectors. Without it the synchroniser output
//   is used directly and no counters are built.
module gpio_slave_irq #(
    parameter int N_PINS          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 15
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    gpio_slave_irq_if.slave       bus,
    input  logic [N_PINS-1:0]     i_Pin_In,
    output logic [N_PINS-1:0]     o_Pin_Out,
    output logic [N_PINS-1:0]     o_Pin_Oe,
    output logic                  o_Irq
);

    // Elaboration-time parameter sanity checks.
    if (N_PINS < 1 || N_PINS > 32) begin : g_bad_pins
        $error("gpio_slave_irq: N_PINS must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gpio_slave_irq: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("gpio_slave_irq: DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        IDX_DIR       = 4'd0,
        IDX_OUT       = 4'd1,
        IDX_IN        = 4'd2,
        IDX_OUT_SET   = 4'd3,
        IDX_OUT_CLR   = 4'd4,
        IDX_OUT_TGL   = 4'd5,
        IDX_IRQ_EN    = 4'd6,
        IDX_EDGE_RISE = 4'd7,
        IDX_EDGE_FALL = 4'd8,
        IDX_STATUS    = 4'd9
    } reg_idx_e;

    localparam logic [31:0] LAST_IDX = 32'd9;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] sync_q [SYNC_STAGES];
    logic [N_PINS-1:0] sync;
    logic [N_PINS-1:0] pin_val;   // synchronised or debounced pin level

    // NOTE: every flop, including the synchroniser chain, is cleared by the
    // async reset so no X can reach the edge detectors after reset release.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true shift register.
            sync_q[0] <= i_Pin_In;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debouncer: the stable level follows sync only after sync has differed
    // from it for DEBOUNCE_CYCLES+1 consecutive cycles.
    // ------------------------------------------------------------------
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0]  db_cnt_q [N_PINS];
    logic [N_PINS-1:0] stable_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            stable_q <= '0;
            for (int p = 0; p < N_PINS; p++) db_cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < N_PINS; p++) begin
                if (sync[p] == stable_q[p]) begin
                    db_cnt_q[p] <= '0;
                end else if (db_cnt_q[p] == CNT_MAX) begin
                    stable_q[p] <= sync[p];
                    db_cnt_q[p] <= '0;
                end else begin
                    db_cnt_q[p] <= db_cnt_q[p] + 1'b1;
                end
            end
        end
    end

    assign pin_val = stable_q;
`else
    assign pin_val = sync;
`endif

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] prev_q;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) prev_q <= '0;
        else          prev_q <= pin_val;
    end

    assign rise =  pin_val & ~prev_q;
    assign fall = ~pin_val &  prev_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] dir_q, out_q, irq_en_q, rise_en_q, fall_en_q, status_q;
    logic [N_PINS-1:0] wdata_n;
    reg_idx_e          wr_idx;
    reg_idx_e          rd_idx;
    logic              wr_bad;
    logic              wr_ok;
    logic              rd_bad;

    assign wdata_n = bus.i_WData[N_PINS-1:0];
    assign wr_idx  = reg_idx_e'(bus.i_WAddr[3:0]);
    assign rd_idx  = reg_idx_e'(bus.i_RAddr[3:0]);
    assign wr_bad  = (bus.i_WAddr > LAST_IDX) || (bus.i_WAddr == 32'(IDX_IN));
    assign wr_ok   = bus.i_WEnable && !wr_bad;
    assign rd_bad  = bus.i_RAddr > LAST_IDX;

    // STATUS: newly captured events win over a same-cycle W1C clear.
    logic [N_PINS-1:0] status_clr;
    logic [N_PINS-1:0] status_set;
    logic [N_PINS-1:0] status_d;

    assign status_clr = (wr_ok && wr_idx == IDX_STATUS) ? wdata_n : '0;
    assign status_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign status_d   = (status_q & ~status_clr) | status_set;

    // Read mux, zero-extended to the bus width.
    logic [N_PINS-1:0] rd_n;
    logic [31:0]       rd_val;

    always_comb begin
        // NOTE: a default before the case keeps this purely combinational;
        // any path that left rd_n unassigned would infer a latch.
        rd_n = '0;
        case (rd_idx)
            IDX_DIR:       rd_n = dir_q;
            IDX_OUT:       rd_n = out_q;
            IDX_IN:        rd_n = pin_val;
            IDX_IRQ_EN:    rd_n = irq_en_q;
            IDX_EDGE_RISE: rd_n = rise_en_q;
            IDX_EDGE_FALL: rd_n = fall_en_q;
            IDX_STATUS:    rd_n = status_q;
            default:       rd_n = '0;   // write-only and unmapped indices
        endcase
        rd_val = 32'(rd_n);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            status_q <= status_d;
            if (wr_ok) begin
                case (wr_idx)
                    IDX_DIR:       dir_q     <= wdata_n;
                    IDX_OUT:       out_q     <= wdata_n;
                    IDX_OUT_SET:   out_q     <= out_q | wdata_n;
                    IDX_OUT_CLR:   out_q     <= out_q & ~wdata_n;
                    IDX_OUT_TGL:   out_q     <= out_q ^ wdata_n;
                    IDX_IRQ_EN:    irq_en_q  <= wdata_n;
                    IDX_EDGE_RISE: rise_en_q <= wdata_n;
                    IDX_EDGE_FALL: fall_en_q <= wdata_n;
                    default:       ;   // STATUS handled through status_d
                endcase
            end
        end
    end

    // Bus response: a write takes priority and leaves read data untouched;
    // an erroring read also holds the previous read data.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bus.o_RData <= '0;
            bus.o_Err   <= 1'b0;
        end else if (bus.i_WEnable) begin
            bus.o_Err <= wr_bad;
        end else if (bus.i_REnable) begin
            bus.o_Err <= rd_bad;
            if (!rd_bad) bus.o_RData <= rd_val;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) o_Irq <= 1'b0;
        else          o_Irq <= |(status_q & irq_en_q);
    end

    assign o_Pin_Out = out_q;
    assign o_Pin_Oe  = dir_q;

endmodule

// File: tb/tb_gpio_slave_irq.sv
// tb_gpio_slave_irq
//   Directed self-checking bench for gpio_slave_irq in its default build
//   (N_PINS=8, SYNC_STAGES=2, no debouncer). All bus activity is driven and
//   sampled on the falling clock edge; the DUT registers on the rising edge.
module tb_gpio_slave_irq;

    localparam int N_PINS = 8;

    logic              i_Clk;
    logic              i_Rst_n;
    logic [N_PINS-1:0] pin_in;
    logic [N_PINS-1:0] pin_out;
    logic [N_PINS-1:0] pin_oe;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_slave_irq_if bus ();

    gpio_slave_irq #(
        .N_PINS          (N_PINS),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (15)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .bus       (bus),
        .i_Pin_In  (pin_in),
        .o_Pin_Out (pin_out),
        .o_Pin_Oe  (pin_oe),
        .o_Irq     (irq)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered on a falling edge and return on the next one,
    // so the single rising edge in between performs the access.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.i_WEnable = 1'b1;
        bus.i_WAddr   = addr;
        bus.i_WData   = data;
        @(negedge i_Clk);
        bus.i_WEnable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.i_REnable = 1'b1;
        bus.i_RAddr   = addr;
        @(negedge i_Clk);
        bus.i_REnable = 1'b0;
        data = bus.o_RData;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge i_Clk);
    endtask

    logic [31:0] rd;

    initial begin
        bus.i_WEnable = 1'b0;
        bus.i_WAddr   = '0;
        bus.i_WData   = '0;
        bus.i_REnable = 1'b0;
        bus.i_RAddr   = '0;
        pin_in        = '0;
        i_Rst_n       = 1'b0;

        // ---------------- 1. reset state and read-back of every index ----
        idle(3);
        check("rst_rdata", bus.o_RData, 32'h0);
        check("rst_err",   {31'b0, bus.o_Err}, 32'h0);
        check("rst_irq",   {31'b0, irq}, 32'h0);
        check("rst_out",   32'(pin_out), 32'h0);
        check("rst_oe",    32'(pin_oe), 32'h0);
        i_Rst_n = 1'b1;
        idle(1);

        for (int i = 0; i <= 9; i++) begin
            bus_read(32'(i), rd);
            check($sformatf("rst_read_%0d", i), rd, 32'h0);
            check($sformatf("rst_read_err_%0d", i), {31'b0, bus.o_Err}, 32'h0);
        end
        bus_read(32'd10, rd);
        check("rd10_err",  {31'b0, bus.o_Err}, 32'h1);
        check("rd10_hold", rd, 32'h0);

        // ---------------- 2. output register operations ----------------
        bus_write(32'd0, 32'hFF);
        check("dir_oe", 32'(pin_oe), 32'hFF);
        check("wr_err_clr", {31'b0, bus.o_Err}, 32'h0);
        bus_write(32'd1, 32'hA5);
        check("out_wr", 32'(pin_out), 32'hA5);
        bus_write(32'd3, 32'h0F);
        check("out_set", 32'(pin_out), 32'hAF);
        bus_write(32'd4, 32'h81);
        check("out_clr", 32'(pin_out), 32'h2E);
        bus_write(32'd5, 32'hFF);
        check("out_tgl", 32'(pin_out), 32'hD1);
        bus_write(32'd3, 32'hFFFF_FF00);          // only bits above N_PINS set
        check("out_set_hi", 32'(pin_out), 32'hD1);
        bus_read(32'd4, rd);
        check("rd_wo_val", rd, 32'h0);
        check("rd_wo_err", {31'b0, bus.o_Err}, 32'h0);
        bus_read(32'd1, rd);
        check("rd_out", rd, 32'h0000_00D1);
        bus_read(32'd15, rd);
        check("rd15_err",  {31'b0, bus.o_Err}, 32'h1);
        check("rd15_hold", rd, 32'h0000_00D1);
        bus_write(32'd12, 32'h00);
        check("wr12_err", {31'b0, bus.o_Err}, 32'h1);
        check("wr12_out", 32'(pin_out), 32'hD1);
        check("wr12_rdata_hold", bus.o_RData, 32'h0000_00D1);

        // ---------------- 3. rising edge -> STATUS -> IRQ --------------
        bus_write(32'd7, 32'h01);
        bus_write(32'd6, 32'h01);
        pin_in[0] = 1'b1;                        // cycle t (rising edge t+1)
        idle(1);
        check("rise_irq_t1", {31'b0, irq}, 32'h0);
        bus_read(32'd2, rd);                      // sampled at edge t+2 (pre)
        check("in_t1", rd, 32'h00);
        bus_read(32'd2, rd);                      // sampled at edge t+3
        check("in_t2", rd, 32'h01);
        check("rise_irq_t3", {31'b0, irq}, 32'h0);
        bus_read(32'd9, rd);
        check("status_t3", rd, 32'h01);
        check("rise_irq_t4", {31'b0, irq}, 32'h1);
        bus_write(32'd9, 32'h01);                 // W1C
        check("w1c_irq_1", {31'b0, irq}, 32'h1);
        idle(1);
        check("w1c_irq_2", {31'b0, irq}, 32'h0);
        bus_read(32'd9, rd);
        check("w1c_status", rd, 32'h00);

        // ---------------- 4. fall edge coincident with W1C --------------
        pin_in[1] = 1'b1;                         // rise on pin1 not enabled
        idle(4);
        bus_write(32'd8, 32'h02);
        bus_read(32'd9, rd);
        check("pin1_rise_ignored", rd, 32'h00);
        pin_in[1] = 1'b0;                         // fall visible 2 edges on
        idle(2);
        bus_write(32'd9, 32'h02);                 // same edge STATUS[1] sets
        bus_read(32'd9, rd);
        check("set_wins", rd, 32'h02);
        check("masked_irq", {31'b0, irq}, 32'h0);
        bus_write(32'd6, 32'h03);
        check("irq_en_irq_0", {31'b0, irq}, 32'h0);
        idle(1);
        check("irq_en_irq_1", {31'b0, irq}, 32'h1);
        bus_write(32'd6, 32'h00);
        check("irq_dis_1", {31'b0, irq}, 32'h1);
        idle(1);
        check("irq_dis_2", {31'b0, irq}, 32'h0);
        bus_read(32'd9, rd);
        check("irq_dis_status", rd, 32'h02);
        bus_write(32'd9, 32'h02);
        bus_read(32'd9, rd);
        check("status_clear2", rd, 32'h00);

        // ---------------- 5. write to IN, simultaneous strobes ----------
        bus_write(32'd2, 32'hFF);
        check("wr_in_err", {31'b0, bus.o_Err}, 32'h1);
        bus_read(32'd2, rd);
        check("wr_in_unchanged", rd, 32'h01);
        check("rd_in_err_clr", {31'b0, bus.o_Err}, 32'h0);
        bus.i_REnable = 1'b1;
        bus.i_RAddr   = 32'd1;
        bus_write(32'd0, 32'h3C);
        bus.i_REnable = 1'b0;
        check("wr_rd_oe",    32'(pin_oe), 32'h3C);
        check("wr_rd_rdata", bus.o_RData, 32'h01);
        check("wr_rd_err",   {31'b0, bus.o_Err}, 32'h0);

        // ---------------- reset mid-operation ---------------------------
        bus_write(32'd7, 32'h04);
        bus_write(32'd6, 32'h04);
        pin_in[2] = 1'b1;
        idle(5);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        #2 i_Rst_n = 1'b0;
        #1;
        check("async_rst_irq",   {31'b0, irq}, 32'h0);
        check("async_rst_out",   32'(pin_out), 32'h0);
        check("async_rst_oe",    32'(pin_oe), 32'h0);
        check("async_rst_rdata", bus.o_RData, 32'h0);
        idle(2);
        i_Rst_n = 1'b1;                           // pins 0 and 2 still high
        idle(5);
        bus_read(32'd9, rd);
        check("post_rst_status", rd, 32'h00);
        bus_read(32'd2, rd);
        check("post_rst_in", rd, 32'h05);
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_slave_irq.md
Name: gpio_slave_irq

Overview:
Parametrised GPIO bus slave, successor to the fixed 4-pin GPIO slave. It provides N_PINS pins with per-pin direction control and atomic set, clear and toggle of the output register. It also provides a synchronised input path and per-pin rising/falling edge detection, with write-1-to-clear status and a single level interrupt output. It sits on the SoC peripheral bus using the same word-indexed register access and o_Err signalling as the other peripherals.

Parameters:
N_PINS, 8, number of GPIO pins (1..32); register bits above N_PINS-1 read 0 and ignore writes
SYNC_STAGES, 2, flip-flop stages on i_Pin_In (minimum 2)
DEBOUNCE_CYCLES, 15, consecutive stable cycles required before the debounced value changes (used only with GPIO_DEBOUNCE_EN)

Ports:
i_Clk  in  1  system clock; one clock, all logic on rising edge
i_Rst_n  in  1  reset; reset is asynchronous and active-low
i_WEnable  in  1  write strobe, one cycle per access
i_WAddr  in  32  write word index
i_WData  in  32  write data
i_REnable  in  1  read strobe, one cycle per access
i_RAddr  in  32  read word index
o_RData  out  32  registered read data
o_Err  out  1  registered access error
i_Pin_In  in  N_PINS  asynchronous pin inputs
o_Pin_Out  out  N_PINS  output register value (OUT)
o_Pin_Oe  out  N_PINS  output enable (DIR); 1 = drive
o_Irq  out  1  registered interrupt, |(STATUS & IRQ_EN)

Behaviour:
- Reset (asynchronous, i_Rst_n=0) clears: all registers, synchroniser and edge-history flops, o_RData=0, o_Err=0, o_Irq=0.
- Register map, by word index:
  - 0 DIR, RW
  - 1 OUT, RW
  - 2 IN, RO: synchronised (or debounced) pins
  - 3 OUT_SET, WO: OUT |= wdata
  - 4 OUT_CLR, WO: OUT &= ~wdata
  - 5 OUT_TGL, WO: OUT ^= wdata
  - 6 IRQ_EN, RW
  - 7 EDGE_RISE, RW: enables rising-edge capture
  - 8 EDGE_FALL, RW: enables falling-edge capture
  - 9 STATUS, RW1C
- Write access: register updates at the clock edge on which i_WEnable=1; o_Err<=0.
- Read access: o_RData is valid the cycle after i_REnable; the value is zero-extended to 32 bits; o_Err<=0.
- Read of index 3/4/5 returns 0 with o_Err=0.
- Error cases, each setting o_Err<=1 with no register change and o_RData held:
  - any index > 9
  - a write to index 2
- When no strobe is present, o_RData and o_Err hold their values.
- If i_WEnable and i_REnable are both high, the write is serviced and the read is ignored.
- Input path: SYNC_STAGES flop chain produces sync. Each cycle, prev<=sync.
  - rise = sync & ~prev
  - fall = ~sync & prev
- Edge capture: STATUS[i] sets when (rise[i]&EDGE_RISE[i]) | (fall[i]&EDGE_FALL[i]). Capture is independent of DIR and IRQ_EN.
- W1C versus capture: a STATUS write clears the bits written as 1. If a new event occurs in the same cycle as a clearing write, set wins and the bit stays 1.
- Interrupt output: o_Irq <= |(STATUS & IRQ_EN), i.e. it asserts one cycle after the STATUS bit sets.
- Edge-to-interrupt latency: a pin edge is visible in IN after SYNC_STAGES cycles; STATUS sets 1 cycle later; o_Irq asserts 1 cycle after that.
- A pin high during reset produces a rise event SYNC_STAGES cycles after reset release. It is captured only if EDGE_RISE was already set; after reset EDGE_RISE=0, so nothing is captured.
- Clearing IRQ_EN deasserts o_Irq on the next cycle without affecting STATUS.
- Reset asserted mid-operation clears everything immediately, including pending STATUS bits.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined:
  - Each pin has a counter of width clog2(DEBOUNCE_CYCLES+1) and a stable flop.
  - While sync != stable, the counter increments; when the counter reaches DEBOUNCE_CYCLES, stable<=sync and the counter clears.
  - Any cycle with sync == stable clears the counter.
  - IN and edge detection use stable, which adds DEBOUNCE_CYCLES+1 cycles of latency.
- Not defined: stable is replaced by sync directly; no counters are built.

Test Plan:
1. Reset, then read indices 0..9 -> all return 0 with o_Err=0; read index 10 -> o_Err=1 and o_RData unchanged.
2. Write OUT=0xA5, then OUT_SET=0x0F, OUT_CLR=0x81, OUT_TGL=0xFF -> OUT takes 0xAF, then 0x2E, then 0xD1. o_Pin_Out follows one cycle after each write; DIR=0xFF gives o_Pin_Oe=0xFF.
3. EDGE_RISE=0x01, IRQ_EN=0x01, drive i_Pin_In[0] 0->1 at cycle t -> IN[0]=1 at t+2, STATUS=0x01 at t+3, o_Irq=1 at t+4. Write STATUS=0x01 -> o_Irq=0 two cycles later.
4. EDGE_FALL=0x02, pulse pin1 low with the falling edge aligned to a STATUS=0x02 W1C write -> STATUS[1] remains 1.
5. Write index 2 -> o_Err=1 and IN unchanged. Assert i_WEnable and i_REnable together at index 0 -> DIR written, o_RData unchanged.
6. (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=15) a 10-cycle glitch on pin2 -> IN[2] stays 0 and no STATUS bit. A 20-cycle high on pin2 -> IN[2]=1 at SYNC_STAGES+16 cycles after the edge.
